// File: rtl/fnn_pkg.sv
// Shared types and width helpers for the fixed-point neuron datapath.
package fnn_pkg;

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_FINAL, S_OUT} neuron_state_t;

  localparam int DATA_WIDTH = 16;

  function automatic int accWidth(input int data_w, input int num_weight);
    return 2 * data_w + $clog2(num_weight);
  endfunction

  function automatic longint sat_max(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DATA_WIDTH);
  localparam longint SAT_MIN = sat_min(DATA_WIDTH);

endpackage

// File: rtl/neuron_mac_if.sv
// Activation stream in, weight-memory port, activation stream out.
interface neuron_mac_if #(
  parameter int numWeight    = 30,
  parameter int dataWidth    = 16,
  parameter int addressWidth = $clog2(numWeight)
);
  logic                        in_valid;
  logic signed [dataWidth-1:0] in_data;
  logic                        in_ready;

  logic                          w_ren;
  logic [addressWidth-1:0]       w_radd;
  logic                          w_wen;
  logic [addressWidth-1:0]       w_wadd;
  logic signed [dataWidth-1:0]   w_win;
  logic signed [dataWidth-1:0]   w_data;

  logic                 out_valid;
  logic [dataWidth-1:0] out_data;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_ren, w_radd, w_wen, w_wadd, w_win, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_ren, w_radd, w_wen, w_wadd, w_win, out_valid, out_data
  );
endinterface

// File: rtl/relu_sat.sv
// Rescales a wide accumulator back to activation format, saturates and applies ReLU.
module relu_sat
  import fnn_pkg::*;
#(
  parameter int dataWidth = DATA_WIDTH,
  parameter int fracBits  = 12,
  parameter int accW      = accWidth(DATA_WIDTH, 30)
) (
  input  logic signed [accW-1:0]  sum_i,
  output logic [dataWidth-1:0]    res_o
);

  localparam logic signed [accW-1:0] MaxV = accW'(sat_max(dataWidth));
  localparam logic signed [accW-1:0] MinV = accW'(sat_min(dataWidth));

  logic signed [accW-1:0]      shifted;
  logic signed [dataWidth-1:0] sat;

  // NOTE: every output gets a value before any branch, so no latch is inferred.
  always_comb begin
    shifted = sum_i >>> fracBits;
    sat     = shifted[dataWidth-1:0];
    if (shifted > MaxV)      sat = MaxV[dataWidth-1:0];
    else if (shifted < MinV) sat = MinV[dataWidth-1:0];
    res_o = sat[dataWidth-1] ? '0 : sat;
  end

endmodule

// File: rtl/neuron_mac.sv
// One neuron: streamed multiply-accumulate against its weight memory, bias, rescale, ReLU.
module neuron_mac
  import fnn_pkg::*;
#(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = DATA_WIDTH,
  parameter int fracBits     = 12,
  parameter int biasValue    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  neuron_mac_if.slave  bus
);

  localparam int AccW = accWidth(dataWidth, numWeight);
  localparam int ProdW = 2 * dataWidth;
  localparam logic [addressWidth-1:0] LastIdx = addressWidth'(numWeight - 1);
  localparam logic signed [dataWidth-1:0] BiasD = dataWidth'(biasValue);
  localparam logic signed [AccW-1:0] BiasExt = AccW'(BiasD) <<< fracBits;

  neuron_state_t               state_q;
  logic [addressWidth-1:0]     cnt_q;
  logic                        drain_q;
  logic                        s1_valid_q;
  logic signed [dataWidth-1:0] s1_data_q;
  logic                        s2_valid_q;
  logic signed [ProdW-1:0]     prod_q;
  logic signed [AccW-1:0]      acc_q;
  logic                        out_valid_q;
  logic [dataWidth-1:0]        out_data_q;

  logic                 in_ready;
  logic                 accept;
  logic signed [AccW-1:0] sum;
  logic [dataWidth-1:0] relu_res;

  assign in_ready = (state_q == S_ACC);
  assign accept   = bus.in_valid & in_ready;
  assign sum      = acc_q + BiasExt;

  relu_sat #(
    .dataWidth(dataWidth),
    .fracBits (fracBits),
    .accW     (AccW)
  ) u_relu_sat (
    .sum_i(sum),
    .res_o(relu_res)
  );

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_data_q <= bus.in_data;
      // w_data arrives one cycle after the read, aligned with stage 1
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) prod_q <= ProdW'(s1_data_q) * ProdW'(bus.w_data);
      if (s2_valid_q) acc_q <= acc_q + AccW'(prod_q);

      unique case (state_q)
        S_ACC: begin
          if (accept) begin
            if (cnt_q == LastIdx) begin
              cnt_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              cnt_q <= cnt_q + addressWidth'(1);
            end
          end
        end
        S_DRAIN: begin
          drain_q <= ~drain_q;
          if (drain_q) state_q <= S_FINAL;
        end
        S_FINAL: begin
          out_data_q  <= relu_res;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            state_q     <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.w_ren     = accept;
  assign bus.w_radd    = cnt_q;
  assign bus.w_wen     = 1'b0;
  assign bus.w_wadd    = '0;
  assign bus.w_win     = '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Two neurons (bias 0.0 and 1.0) run in lockstep against a reference model and scoreboard.
module tb_neuron_mac;
  import fnn_pkg::*;

  localparam int NW = 30;
  localparam int DW = 16;
  localparam int FB = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] wd0 = '0, wd1 = '0;
  logic signed [DW-1:0] wmem [NW];

  neuron_mac_if #(.numWeight(NW), .dataWidth(DW)) bus0 ();
  neuron_mac_if #(.numWeight(NW), .dataWidth(DW)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus0.w_data    = wd0;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;
  assign bus1.w_data    = wd1;

  always @(posedge clk) begin
    if (bus0.w_ren) wd0 <= wmem[bus0.w_radd];
    if (bus1.w_ren) wd1 <= wmem[bus1.w_radd];
  end

  neuron_mac #(.numWeight(NW), .dataWidth(DW), .fracBits(FB), .biasValue(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  neuron_mac #(.numWeight(NW), .dataWidth(DW), .fracBits(FB), .biasValue(4096)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input int acts[NW], input int ws[NW], input int bias);
    longint acc = 0;
    longint res;
    longint scale = longint'(1) << FB;
    for (int i = 0; i < NW; i++) acc += longint'(acts[i]) * longint'(ws[i]);
    acc += longint'(bias) * scale;
    if (acc >= 0) res = acc / scale;
    else          res = -((-acc + scale - 1) / scale);
    if (res > 32767) res = 32767;
    if (res < 0)     res = 0;
    return res[DW-1:0];
  endfunction

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int a_case[NW];
  int w_case[NW];

  // Monitor: address sequence, read enables, output latency and scoreboard.
  int exp_addr = 0;
  int last_acc = 0;
  bit ov_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr = 0;
      ov_prev  = 1'b0;
    end else begin
      check("w_ren0", bus0.w_ren, in_valid & bus0.in_ready);
      check("w_ren1", bus1.w_ren, in_valid & bus1.in_ready);
      if (bus0.w_ren) begin
        check("w_radd0", bus0.w_radd, exp_addr);
        check("w_radd1", bus1.w_radd, exp_addr);
        exp_addr = (exp_addr == NW - 1) ? 0 : exp_addr + 1;
        last_acc = cyc;
      end
      if (bus0.out_valid && !ov_prev) check("latency", cyc - last_acc, 4);
      ov_prev = bus0.out_valid;
      if (bus0.out_valid && out_ready) begin
        if (exp_q0.size() == 0) check("unexpected_out0", 1, 0);
        else check("out_data0", bus0.out_data, exp_q0.pop_front());
      end
      if (bus1.out_valid && out_ready) begin
        if (exp_q1.size() == 0) check("unexpected_out1", 1, 0);
        else check("out_data1", bus1.out_data, exp_q1.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int budget = 0;
    while (!bus0.in_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200) check("in_ready_timeout", 0, 1);
  endtask

  task automatic drive_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wait_ready();
      in_valid = 1'b1;
      in_data  = DW'(a_case[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input bit gaps);
    for (int i = 0; i < NW; i++) wmem[i] = DW'(w_case[i]);
    exp_q0.push_back(model(a_case, w_case, 0));
    exp_q1.push_back(model(a_case, w_case, 4096));
    drive_frame(NW, gaps);
  endtask

  task automatic set_case(input int kind);
    for (int i = 0; i < NW; i++) begin
      case (kind)
        1: begin a_case[i] = 4096; w_case[i] = 4096; end
        2: begin a_case[i] = (i == 0) ? 2048 : 0; w_case[i] = 4096; end
        3: begin a_case[i] = (i == 0) ? 4096 : 0; w_case[i] = (i == 0) ? -4096 : 4096; end
        default: begin
          a_case[i] = int'($urandom_range(0, 4095)) - 2048;
          w_case[i] = int'($urandom_range(0, 4095)) - 2048;
        end
      endcase
    end
  endtask

  initial begin
    #3;
    check("rst_in_ready0", bus0.in_ready, 1);
    check("rst_in_ready1", bus1.in_ready, 1);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_out_data", bus0.out_data, 0);
    check("rst_w_ren", bus0.w_ren, 0);
    check("rst_w_wen", bus0.w_wen, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_case(1); run_frame(1'b0);
    set_case(2); run_frame(1'b0);
    set_case(3); run_frame(1'b0);
    set_case(2); run_frame(1'b1);
    set_case(0); run_frame(1'b1);

    // Backpressure: hold the result for five cycles while offering input
    set_case(2); run_frame(1'b0);
    out_ready = 1'b0;
    begin
      int budget = 0;
      while (!bus0.out_valid && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      if (budget >= 20) check("out_valid_timeout", 0, 1);
    end
    in_valid = 1'b1;
    in_data  = 16'sd123;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", bus0.out_valid, 1);
      check("stall_data0", bus0.out_data, exp_q0[0]);
      check("stall_data1", bus1.out_data, exp_q1[0]);
      check("stall_in_ready", bus0.in_ready, 0);
      check("stall_w_ren", bus0.w_ren, 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-frame after ten inputs, then a full clean frame
    set_case(2);
    for (int i = 0; i < NW; i++) wmem[i] = DW'(w_case[i]);
    drive_frame(10, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_radd0", bus0.w_radd, 0);
    check("mid_rst_radd1", bus1.w_radd, 0);
    check("mid_rst_in_ready", bus0.in_ready, 1);
    check("mid_rst_out_valid", bus0.out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0);

    begin
      int budget = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 100) begin
        @(posedge clk); #1;
        budget++;
      end
      check("q0_drained", exp_q0.size(), 0);
      check("q1_drained", exp_q1.size(), 0);
    end
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
